// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_pkg
// Brief    : Shared constants and types for the mesh router output stage:
//            port count, port-index names and the output arbiter state type.
// Revision : 1.0 - initial release
// ============================================================================
package router_pkg;

  // Number of router ports (four mesh directions plus the local port)
  localparam int NUM_PORTS = 5;

  // Port index assignment used throughout the router
  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_S = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;

  // Output arbiter states: free to arbitrate, or wormhole-locked to one input
  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin selector. Returns the first set request
//            at or after ptr, wrapping modulo NUM_IN, as a one-hot vector and a
//            binary index, plus an any-request flag.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import router_pkg::*;
#(
  parameter int NUM_IN = NUM_PORTS
) (
  input  logic [NUM_IN-1:0]         req,
  input  logic [$clog2(NUM_IN)-1:0] ptr,
  output logic [NUM_IN-1:0]         pick,
  output logic [$clog2(NUM_IN)-1:0] idx,
  output logic                      any
);

  localparam int IW = $clog2(NUM_IN);

  logic [NUM_IN-1:0] w_mask_hi;  // positions at or above ptr
  logic [NUM_IN-1:0] w_req_hi;   // requests at or above ptr
  logic [NUM_IN-1:0] w_src;      // vector the lowest-bit search runs on

  // Mark every position at or above the current priority pointer
  always_comb begin
    w_mask_hi = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_mask_hi[i] = (IW'(i) >= ptr);
    end
  end

  // Prefer requests at or above ptr; if none, wrap around to the full vector
  always_comb begin
    w_req_hi = req & w_mask_hi;
    w_src    = (|w_req_hi) ? w_req_hi : req;
    any      = |req;
  end

  // Lowest set bit of the selected vector; scanning downward lets the lowest win
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (w_src[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
        idx     = IW'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/output_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : output_port_arbiter
// Brief    : Packet-level round-robin arbiter for one router output port.
//            Grants the link on a head flit, holds it (wormhole lock) until the
//            granted input's tail flit transfers, then rotates priority.
//            Optional stall watchdog enabled by defining ROUTER_ARB_TIMEOUT_EN,
//            which adds the timeout_err port.
// Revision : 1.0 - initial release
// ============================================================================
module output_port_arbiter
  import router_pkg::*;
#(
  parameter int NUM_IN      = NUM_PORTS,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IN-1:0]         req_valid,
  input  logic [NUM_IN-1:0]         req_tail,
  input  logic                      out_ready,
  output logic [NUM_IN-1:0]         grant,
  output logic [$clog2(NUM_IN)-1:0] grant_idx,
  output logic                      busy,
  output logic                      fire
`ifdef ROUTER_ARB_TIMEOUT_EN
  ,
  output logic                      timeout_err
`endif
);

  localparam int IW = $clog2(NUM_IN);
  localparam logic [IW-1:0] c_LAST_IDX = IW'(NUM_IN - 1);

  // Reject configurations the pointer/index logic cannot represent
  if ((NUM_IN < 2) || (TIMEOUT_CYC < 1)) begin : g_cfg_check
    $error("output_port_arbiter: NUM_IN must be >= 2 and TIMEOUT_CYC >= 1");
  end

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     w_ptr_nxt;
  logic [NUM_IN-1:0] w_pick;
  logic [IW-1:0]     w_pick_idx;
  logic              w_any;
  logic              w_tail_fire;
  logic              w_timeout;
  logic              w_release;

  rr_pick #(
    .NUM_IN (NUM_IN)
  ) u_rr_pick (
    .req  (req_valid),
    .ptr  (r_ptr),
    .pick (w_pick),
    .idx  (w_pick_idx),
    .any  (w_any)
  );

  // Priority moves to the input just after the winner, wrapping at the top
  assign w_ptr_nxt = (w_pick_idx == c_LAST_IDX) ? '0 : w_pick_idx + 1'b1;

  // The lock ends on the tail transfer or on a watchdog expiry
  assign w_release = w_tail_fire | w_timeout;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: lock on any request, unlock on release
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE:   if (w_any)     w_state_nxt = ARB_LOCKED;
      ARB_LOCKED: if (w_release) w_state_nxt = ARB_IDLE;
      default:                   w_state_nxt = ARB_IDLE;
    endcase
  end

  // Transfer handshake: only the locked input may move a flit, never in IDLE
  always_comb begin
    fire        = (r_state == ARB_LOCKED) & (|(req_valid & grant)) & out_ready;
    w_tail_fire = fire & (|(req_tail & grant));
  end

  // Grant, index, busy and priority pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant     <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
      r_ptr     <= '0;
    end else if (r_state == ARB_IDLE) begin
      if (w_any) begin
        grant     <= w_pick;
        grant_idx <= w_pick_idx;
        busy      <= 1'b1;
        r_ptr     <= w_ptr_nxt;
      end
    end else if (w_release) begin
      grant     <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
    end
  end

`ifdef ROUTER_ARB_TIMEOUT_EN
  localparam int            c_CNT_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LIMIT = c_CNT_W'(TIMEOUT_CYC);

  logic [c_CNT_W-1:0] r_stall_cnt;

  // A locked output that has stalled TIMEOUT_CYC cycles is released next edge
  assign w_timeout = (r_state == ARB_LOCKED) & ~fire & (r_stall_cnt == c_CNT_LIMIT);

  // Stall counter: zero outside LOCKED and on every transfer; saturates at limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= w_timeout;
      if ((r_state != ARB_LOCKED) || fire) begin
        r_stall_cnt <= '0;
      end else if (r_stall_cnt != c_CNT_LIMIT) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_output_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_port_arbiter
// Brief    : Directed self-checking bench for output_port_arbiter. Inputs are
//            driven on the falling edge and outputs sampled 1 ns later, so each
//            step describes one full cycle ahead of the next rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_port_arbiter;

  localparam int NUM_IN = 5;
  localparam int IW     = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_IN-1:0] req_valid;
  logic [NUM_IN-1:0] req_tail;
  logic              out_ready;
  logic [NUM_IN-1:0] grant;
  logic [IW-1:0]     grant_idx;
  logic              busy;
  logic              fire;
`ifdef ROUTER_ARB_TIMEOUT_EN
  logic              timeout_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  output_port_arbiter #(
    .NUM_IN      (NUM_IN),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_tail    (req_tail),
    .out_ready   (out_ready),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .fire        (fire)
`ifdef ROUTER_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the four always-present outputs at once
  task automatic expect_out(input string tag, input logic [31:0] g, input logic [31:0] idx,
                            input logic [31:0] b, input logic [31:0] f);
    chk({tag, ".grant"}, 32'(grant), g);
    chk({tag, ".grant_idx"}, 32'(grant_idx), idx);
    chk({tag, ".busy"}, 32'(busy), b);
    chk({tag, ".fire"}, 32'(fire), f);
  endtask

  // Drive one cycle of inputs on the falling edge, then let them settle
  task automatic step(input logic [NUM_IN-1:0] rv, input logic [NUM_IN-1:0] tl, input logic rdy);
    @(negedge clk);
    req_valid = rv;
    req_tail  = tl;
    out_ready = rdy;
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_tail  = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    expect_out("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two single-flit packets from inputs 2 and 4, ptr starts at 0
    step(5'b10100, 5'b11111, 1'b1); expect_out("t1_idle",   0,        0, 0, 0);
    step(5'b10100, 5'b11111, 1'b1); expect_out("t1_g2",     5'b00100, 2, 1, 1);
    step(5'b10000, 5'b11111, 1'b1); expect_out("t1_bubble", 0,        0, 0, 0);
    step(5'b10000, 5'b11111, 1'b1); expect_out("t1_g4",     5'b10000, 4, 1, 1);
    step(5'b00000, 5'b00000, 1'b1); expect_out("t1_done",   0,        0, 0, 0);

    // Three-flit packet on input 1 while input 3 waits; ptr is 0 again
    step(5'b01010, 5'b01000, 1'b1); expect_out("t2_idle", 0,        0, 0, 0);
    step(5'b01010, 5'b01000, 1'b1); expect_out("t2_f1",   5'b00010, 1, 1, 1);
    step(5'b01010, 5'b01000, 1'b1); expect_out("t2_f2",   5'b00010, 1, 1, 1);
    step(5'b01010, 5'b01010, 1'b1); expect_out("t2_f3",   5'b00010, 1, 1, 1);
    step(5'b01000, 5'b01000, 1'b1); expect_out("t2_gap",  0,        0, 0, 0);
    step(5'b01000, 5'b01000, 1'b1); expect_out("t2_g3",   5'b01000, 3, 1, 1);
    step(5'b00000, 5'b00000, 1'b1); expect_out("t2_done", 0,        0, 0, 0);

    // ptr is 4: input 1 wins over 3 by wrap-around, then drops valid for 4 cycles
    step(5'b01010, 5'b01000, 1'b1); expect_out("t3_idle", 0,        0, 0, 0);
    step(5'b01010, 5'b01000, 1'b1); expect_out("t3_f1",   5'b00010, 1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(5'b01000, 5'b01000, 1'b1); expect_out("t3_drop", 5'b00010, 1, 1, 0);
    end
    step(5'b01010, 5'b01010, 1'b1); expect_out("t3_tail", 5'b00010, 1, 1, 1);
    step(5'b01000, 5'b01000, 1'b1); expect_out("t3_gap",  0,        0, 0, 0);

    // Input 3 now locked; downstream back-pressure for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step(5'b01000, 5'b00000, 1'b0); expect_out("t4_stall", 5'b01000, 3, 1, 0);
    end
    step(5'b01000, 5'b01000, 1'b1); expect_out("t4_tail", 5'b01000, 3, 1, 1);
    step(5'b00000, 5'b00000, 1'b1); expect_out("t4_done", 0,        0, 0, 0);

    // Asynchronous reset in the middle of a packet on input 2
    step(5'b00100, 5'b00000, 1'b1); expect_out("t6_idle", 0,        0, 0, 0);
    step(5'b00100, 5'b00000, 1'b1); expect_out("t6_lock", 5'b00100, 2, 1, 1);
    #2 rst_n = 1'b0;
    #1 expect_out("t6_async", 0, 0, 0, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 5'b11111;
    req_tail  = 5'b11111;
    out_ready = 1'b1;
    #1 expect_out("t6_release", 0, 0, 0, 0);

    // All inputs requesting single-flit packets: 0,1,2,3,4,0,... one grant per 2 cycles
    for (int k = 0; k < 10; k++) begin
      step(5'b11111, 5'b11111, 1'b1);
      expect_out("t5_grant", 32'(1) << (k % 5), 32'(k % 5), 1, 1);
      if (k == 9) step(5'b00000, 5'b00000, 1'b1);
      else        step(5'b11111, 5'b11111, 1'b1);
      expect_out("t5_bubble", 0, 0, 0, 0);
    end

`ifdef ROUTER_ARB_TIMEOUT_EN
    // ptr is 0: input 0 locks and stalls; watchdog fires after 8 stalled cycles
    step(5'b00011, 5'b00000, 1'b0); expect_out("to_idle", 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      step(5'b00011, 5'b00000, 1'b0);
      expect_out("to_stall", 5'b00001, 0, 1, 0);
      chk("to_stall.err", 32'(timeout_err), 0);
    end
    step(5'b00011, 5'b00000, 1'b0);
    expect_out("to_expire", 0, 0, 0, 0);
    chk("to_expire.err", 32'(timeout_err), 1);
    step(5'b00011, 5'b00000, 1'b0);
    expect_out("to_next", 5'b00010, 1, 1, 0);
    chk("to_next.err", 32'(timeout_err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
